// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-side memory stage for a single-cycle core.
//   Word-organised RAM with byte/half/word stores, sign/zero-extended
//   combinational loads, tohost and free-running cycle-counter MMIO
//   registers, and a sticky fault flag for misaligned/illegal stores.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   memwrite            - store strobe
//   memsize[2:0]        - funct3 access type
//   addr[31:0]          - byte address
//   writedata[31:0]     - right-aligned store data
//   readdata[31:0]      - extended load result (combinational)
//   tohost[31:0]        - last word stored to TOHOST_ADDR
//   tohost_valid        - one-cycle pulse after a tohost store
//   misalign_err        - sticky store-fault flag
//   err_addr[31:0]      - address of the first faulting store
module dmem_ctrl #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] TOHOST_ADDR = 32'hFFFF_FFF0,
  parameter logic [31:0] CYCLE_ADDR  = 32'hFFFF_FFF4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [2:0]  memsize,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [31:0] tohost,
  output logic        tohost_valid,
  output logic        misalign_err,
  output logic [31:0] err_addr
);
  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [31:0]   tohost_q, tohost_d;
  logic          tv_q, tv_d;
  logic [31:0]   cyc_q, cyc_d;
  logic          err_q, err_d;
  logic [31:0]   err_addr_q, err_addr_d;

  logic [AW-1:0] idx;
  logic          is_toh, is_cyc, is_word;
  logic          size_legal, aligned, acc_ok;
  logic          st_fault, st_toh, st_cyc, st_ram;
  logic [3:0]    be;
  logic [31:0]   wd_lane;
  logic [31:0]   rword, ext;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;

  // Upper address bits are dropped: RAM aliases modulo its size.
  assign idx     = addr[AW+1:2];
  assign is_toh  = (addr == TOHOST_ADDR);
  assign is_cyc  = (addr == CYCLE_ADDR);
  assign is_word = (memsize == 3'b010);

  always_comb begin
    size_legal = 1'b1;
    aligned    = 1'b1;
    case (memsize)
      3'b000, 3'b100: aligned = 1'b1;
      3'b001, 3'b101: aligned = ~addr[0];
      3'b010:         aligned = (addr[1:0] == 2'b00);
      default:        size_legal = 1'b0;
    endcase
  end
  assign acc_ok = size_legal & aligned;

  // MMIO registers accept only full-word stores; anything else faults.
  assign st_fault = memwrite & (~acc_ok | ((is_toh | is_cyc) & ~is_word));
  assign st_toh   = memwrite & acc_ok & is_toh & is_word;
  assign st_cyc   = memwrite & acc_ok & is_cyc & is_word;
  assign st_ram   = memwrite & acc_ok & ~is_toh & ~is_cyc;

  // Replicate store data across lanes so each enabled lane picks its slice.
  // memsize[2] (unsigned) is irrelevant for stores.
  always_comb begin
    be      = 4'b0000;
    wd_lane = writedata;
    case (memsize[1:0])
      2'b00: begin
        be[addr[1:0]] = 1'b1;
        wd_lane       = {4{writedata[7:0]}};
      end
      2'b01: begin
        be      = addr[1] ? 4'b1100 : 4'b0011;
        wd_lane = {2{writedata[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  // RAM is never cleared; reset only suppresses the write.
  always_ff @(posedge clk) begin
    if (!reset && st_ram) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem_q[idx][8*b +: 8] <= wd_lane[8*b +: 8];
    end
  end

  always_comb begin
    tohost_d   = st_toh ? writedata : tohost_q;
    tv_d       = st_toh;
    cyc_d      = st_cyc ? writedata : cyc_q + 32'd1;
    err_d      = err_q | st_fault;
    err_addr_d = (st_fault && !err_q) ? addr : err_addr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tohost_q   <= '0;
      tv_q       <= 1'b0;
      cyc_q      <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      tohost_q   <= tohost_d;
      tv_q       <= tv_d;
      cyc_q      <= cyc_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Combinational load path sees pre-edge state (read-during-write = old).
  assign rword = is_toh ? tohost_q : (is_cyc ? cyc_q : mem_q[idx]);
  assign rbyte = rword[{addr[1:0], 3'b000} +: 8];
  assign rhalf = rword[{addr[1], 4'b0000} +: 16];

  always_comb begin
    case (memsize)
      3'b000:  ext = {{24{rbyte[7]}}, rbyte};
      3'b100:  ext = {24'h0, rbyte};
      3'b001:  ext = {{16{rhalf[15]}}, rhalf};
      3'b101:  ext = {16'h0, rhalf};
      3'b010:  ext = rword;
      default: ext = 32'h0;
    endcase
  end

  assign readdata     = acc_ok ? ext : 32'h0;
  assign tohost       = tohost_q;
  assign tohost_valid = tv_q;
  assign misalign_err = err_q;
  assign err_addr     = err_addr_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;
  localparam int          D   = 1024;
  localparam logic [31:0] TOH = 32'hFFFF_FFF0;
  localparam logic [31:0] CYC = 32'hFFFF_FFF4;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [2:0]  memsize;
  logic [31:0] addr, writedata, readdata, tohost, err_addr;
  logic        tohost_valid, misalign_err;

  dmem_ctrl #(.DEPTH_WORDS(D), .TOHOST_ADDR(TOH), .CYCLE_ADDR(CYC)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .memsize(memsize),
    .addr(addr), .writedata(writedata), .readdata(readdata),
    .tohost(tohost), .tohost_valid(tohost_valid),
    .misalign_err(misalign_err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference model: byte-addressed memory plus MMIO state.
  logic [7:0]  mm [D*4];
  logic [31:0] m_toh, m_cyc, m_eaddr;
  logic        m_tv, m_err;
  logic [31:0] rd_last;

  function automatic int nbytes(input logic [2:0] s);
    case (s)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input logic [2:0] s);
    int n, off, base;
    logic [31:0] w;
    longint v;
    n = nbytes(s);
    if (n == 0 || (a % n) != 0) return 32'h0;
    if (a == TOH) w = m_toh;
    else if (a == CYC) w = m_cyc;
    else begin
      base = int'(a % (D*4)) & ~3;
      w = {mm[base+3], mm[base+2], mm[base+1], mm[base]};
    end
    if (n == 4) return w;
    off = int'(a % 4);
    v = (longint'(w) >> (8*off)) & ((longint'(1) << (8*n)) - 1);
    if (s < 3'd4 && v >= (longint'(1) << (8*n-1))) v = v - (longint'(1) << (8*n));
    return v[31:0];
  endfunction

  task automatic m_edge(input logic we, input logic [2:0] s, input logic [31:0] a,
                        input logic [31:0] wd, input logic rs);
    int n, base;
    logic fault, mmio;
    if (rs) begin
      m_toh = 0; m_tv = 0; m_cyc = 0; m_err = 0; m_eaddr = 0;
      return;
    end
    m_tv  = 0;
    m_cyc = m_cyc + 1;
    if (we) begin
      n = nbytes(s);
      mmio = (a == TOH) || (a == CYC);
      fault = (n == 0) || ((a % n) != 0) || (mmio && n != 4);
      if (fault) begin
        if (!m_err) m_eaddr = a;
        m_err = 1;
      end else if (a == TOH) begin
        m_toh = wd; m_tv = 1;
      end else if (a == CYC) begin
        m_cyc = wd;
      end else begin
        base = int'(a % (D*4));
        for (int k = 0; k < n; k++) mm[base+k] = 8'((wd >> (8*k)) & 32'hFF);
      end
    end
  endtask

  // One clock cycle: drive, check combinational load, clock, check state.
  task automatic step(input logic we, input logic [2:0] s, input logic [31:0] a,
                      input logic [31:0] wd, input logic rs);
    reset = rs; memwrite = we; memsize = s; addr = a; writedata = wd;
    #1;
    rd_last = readdata;
    if (!rs) chk("readdata", readdata, m_read(a, s));
    @(posedge clk);
    m_edge(we, s, a, wd, rs);
    #1;
    chk("tohost", tohost, m_toh);
    chk("tohost_valid", {31'h0, tohost_valid}, {31'h0, m_tv});
    chk("misalign_err", {31'h0, misalign_err}, {31'h0, m_err});
    chk("err_addr", err_addr, m_eaddr);
  endtask

  task automatic idle(); step(1'b0, 3'd2, 32'h0, 32'h0, 1'b0); endtask
  task automatic ld(input logic [2:0] s, input logic [31:0] a); step(1'b0, s, a, 32'h0, 1'b0); endtask

  initial begin
    logic [31:0] a;
    int r;
    reset = 1; memwrite = 0; memsize = 0; addr = 0; writedata = 0;
    m_toh = 0; m_tv = 0; m_cyc = 0; m_err = 0; m_eaddr = 0;
    @(posedge clk); #1;
    step(1'b0, 3'd2, 32'h0, 32'h0, 1'b1);
    chk("rst_tohost", tohost, 32'h0);
    chk("rst_err", {31'h0, misalign_err}, 32'h0);
    chk("rst_err_addr", err_addr, 32'h0);
    ld(3'd2, CYC);
    chk("cyc_after_rst", rd_last, 32'h0);

    // Clear RAM so model and DUT start from known contents.
    for (int i = 0; i < D; i++) step(1'b1, 3'd2, 32'(i*4), 32'h0, 1'b0);

    // Byte lanes and extension.
    step(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 1'b0);
    ld(3'd0, 32'h103); chk("lb", rd_last, 32'hFFFFFFDE);
    ld(3'd4, 32'h103); chk("lbu", rd_last, 32'h000000DE);
    ld(3'd1, 32'h102); chk("lh", rd_last, 32'hFFFFDEAD);
    ld(3'd5, 32'h102); chk("lhu", rd_last, 32'h0000DEAD);
    ld(3'd2, 32'h100); chk("lw", rd_last, 32'hDEADBEEF);
    step(1'b1, 3'd0, 32'h101, 32'h5A, 1'b0);
    step(1'b1, 3'd1, 32'h102, 32'h1234, 1'b0);
    ld(3'd2, 32'h100); chk("lw_merge", rd_last, 32'h12345AEF);
    ld(3'd2, 32'h102); chk("lw_misalign", rd_last, 32'h0);
    ld(3'd3, 32'h100); chk("ld_illegal", rd_last, 32'h0);

    // First fault wins.
    step(1'b1, 3'd2, 32'h200, 32'hCAFEF00D, 1'b0);
    step(1'b1, 3'd1, 32'h201, 32'h1111, 1'b0);
    step(1'b1, 3'd2, 32'h302, 32'h2222, 1'b0);
    chk("err_flag", {31'h0, misalign_err}, 32'h1);
    chk("err_first", err_addr, 32'h201);
    ld(3'd2, 32'h200); chk("fault_nowrite", rd_last, 32'hCAFEF00D);
    step(1'b0, 3'd2, 32'h0, 32'h0, 1'b1);
    chk("err_clr", {31'h0, misalign_err}, 32'h0);
    chk("err_addr_clr", err_addr, 32'h0);

    // tohost.
    step(1'b1, 3'd2, TOH, 32'h1, 1'b0);
    chk("toh_val", tohost, 32'h1);
    chk("toh_pulse", {31'h0, tohost_valid}, 32'h1);
    idle();
    chk("toh_pulse_end", {31'h0, tohost_valid}, 32'h0);
    ld(3'd2, TOH); chk("toh_load", rd_last, 32'h1);
    step(1'b1, 3'd0, TOH, 32'hAB, 1'b0);
    chk("toh_sb_keep", tohost, 32'h1);
    chk("toh_sb_err", {31'h0, misalign_err}, 32'h1);

    // Cycle counter.
    step(1'b0, 3'd2, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 10; i++) idle();
    ld(3'd2, CYC); chk("cyc_10", rd_last, 32'd10);
    step(1'b1, 3'd2, CYC, 32'hFFFFFFFE, 1'b0);
    ld(3'd2, CYC); chk("cyc_load", rd_last, 32'hFFFFFFFE);
    ld(3'd2, CYC); chk("cyc_max", rd_last, 32'hFFFFFFFF);
    ld(3'd2, CYC); chk("cyc_wrap", rd_last, 32'h0);

    // Reset dominates a tohost store.
    step(1'b1, 3'd2, TOH, 32'h55, 1'b1);
    chk("rst_dom_toh", tohost, 32'h0);
    chk("rst_dom_tv", {31'h0, tohost_valid}, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0) a = TOH;
      else if (r == 1) a = CYC;
      else if (r == 2) a = TOH + 32'($urandom_range(1, 3));
      else a = {$urandom_range(0, 3) == 0 ? 20'($urandom) : 20'h0, 12'($urandom_range(0, 63))};
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
           $urandom_range(0, 99) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
